// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-low glyphs, dp position, display geometry.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_pkg;

    localparam int DIGITS   = 8;
    localparam int NIBBLE_W = 4;
    localparam int DP_BIT   = 7;

    // Active-low glyphs {dp,g,f,e,d,c,b,a}; dp is off (1) in every entry.
    localparam logic [7:0] SEG7_0 = 8'hC0;
    localparam logic [7:0] SEG7_1 = 8'hF9;
    localparam logic [7:0] SEG7_2 = 8'hA4;
    localparam logic [7:0] SEG7_3 = 8'hB0;
    localparam logic [7:0] SEG7_4 = 8'h99;
    localparam logic [7:0] SEG7_5 = 8'h92;
    localparam logic [7:0] SEG7_6 = 8'h82;
    localparam logic [7:0] SEG7_7 = 8'hF8;
    localparam logic [7:0] SEG7_8 = 8'h80;
    localparam logic [7:0] SEG7_9 = 8'h90;
    localparam logic [7:0] SEG7_A = 8'h88;
    localparam logic [7:0] SEG7_B = 8'h83;
    localparam logic [7:0] SEG7_C = 8'hC6;
    localparam logic [7:0] SEG7_D = 8'hA1;
    localparam logic [7:0] SEG7_E = 8'h86;
    localparam logic [7:0] SEG7_F = 8'h8E;

    // Indexed by hex value: SEG7_GLYPH[v] is the glyph for nibble v.
    localparam logic [15:0][7:0] SEG7_GLYPH = {
        SEG7_F, SEG7_E, SEG7_D, SEG7_C, SEG7_B, SEG7_A, SEG7_9, SEG7_8,
        SEG7_7, SEG7_6, SEG7_5, SEG7_4, SEG7_3, SEG7_2, SEG7_1, SEG7_0
    };

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef struct packed {
        logic    legal;
        nibble_t nibble;
    } hex_dec_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Maps the seven segment lines (dp excluded) back to a hex nibble plus a legal flag.
// Latency: purely combinational.
// Backpressure: none.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output hex_dec_t   dec
);

    // Table search against the shared glyphs, with dp forced off
    always_comb begin
        dec = '0;
        for (int i = 0; i < 16; i++) begin
            if ({1'b1, seg} == SEG7_GLYPH[i]) begin
                dec.legal  = 1'b1;
                dec.nibble = NIBBLE_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches a scanned 7-seg display, captures settled digits and rebuilds the 32-bit value.
// Latency: capture SETTLE edges after the edge that registers a new {which,seg}; pulses last one cycle.
// Backpressure: none; dwells shorter than SETTLE+1 clocks are silently ignored.
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  which,
    input  logic [7:0]  seg,
    output logic [31:0] data,
    output logic        valid,
    output logic        err,
    output logic [7:0]  digit_mask
);

    localparam int                CNT_W   = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]  CNT_CAP = CNT_W'(SETTLE - 1);

    logic [2:0]                      r_which;
    logic [7:0]                      r_seg;
    logic [CNT_W-1:0]                cnt;
    logic [DIGITS-1:0][NIBBLE_W-1:0] asm_buf;
    logic [DIGITS-1:0][NIBBLE_W-1:0] asm_next;
    logic [DIGITS-1:0]               mask_next;
    logic                            stable;
    logic                            capture;
    logic                            frame_done;
    hex_dec_t                        dec;

    // Saturation at SETTLE keeps cnt off CNT_CAP for the rest of the dwell,
    // so a held digit is captured exactly once.
    assign stable  = ({which, seg} == {r_which, r_seg});
    assign capture = stable && (cnt == CNT_CAP);

    seg7_hex_decode u_dec (
        .seg (r_seg[DP_BIT-1:0]),
        .dec (dec)
    );

    // Candidate buffer and mask with the digit being captured merged in
    always_comb begin
        asm_next          = asm_buf;
        asm_next[r_which] = dec.nibble;
        mask_next         = digit_mask | (DIGITS'(1) << r_which);
    end

    assign frame_done = (mask_next == '1);

    // Input register and stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_which <= '0;
            r_seg   <= 8'hFF;
            cnt     <= '0;
        end else begin
            r_which <= which;
            r_seg   <= seg;
            if (!stable) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Assembly buffer, coverage mask, frame publish and illegal-glyph flag
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            digit_mask <= '0;
            asm_buf    <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (capture) begin
                if (dec.legal) begin
                    asm_buf <= asm_next;
                    if (frame_done) begin
                        data       <= asm_next;
                        valid      <= 1'b1;
                        digit_mask <= '0;
                    end else begin
                        digit_mask <= mask_next;
                    end
                end else begin
                    // Buffer nibble is left alone; only coverage is withdrawn.
                    err                 <= 1'b1;
                    digit_mask[r_which] <= 1'b0;
                end
            end
        end
    end

endmodule
